// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice per clock, carry held between nibbles.
// Optional subtract mode (adds port sub) when NIBBLE_SERIAL_SUB_EN is defined.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cIn,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] s,
    output logic             cOut
);

    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    count_q, count_d;
`ifdef NIBBLE_SERIAL_SUB_EN
    logic             sub_q, sub_d;
`endif

    // Single CLA_Add4 slice operating on the low nibble of the shift registers
    logic [3:0]       cla_a, cla_b, cla_g, cla_p, cla_sum;
    logic [4:0]       cla_c;
    logic [WIDTH-1:0] acc_shift;

    always_comb begin
        cla_a = x_q[3:0];
`ifdef NIBBLE_SERIAL_SUB_EN
        cla_b = y_q[3:0] ^ {4{sub_q}};
`else
        cla_b = y_q[3:0];
`endif
        cla_g = cla_a & cla_b;
        cla_p = cla_a ^ cla_b;
        cla_c[0] = carry_q;
        cla_c[1] = cla_g[0] | (cla_p[0] & cla_c[0]);
        cla_c[2] = cla_g[1] | (cla_p[1] & cla_g[0]) | (cla_p[1] & cla_p[0] & cla_c[0]);
        cla_c[3] = cla_g[2] | (cla_p[2] & cla_g[1]) | (cla_p[2] & cla_p[1] & cla_g[0])
                 | (cla_p[2] & cla_p[1] & cla_p[0] & cla_c[0]);
        cla_c[4] = cla_g[3] | (cla_p[3] & cla_g[2]) | (cla_p[3] & cla_p[2] & cla_g[1])
                 | (cla_p[3] & cla_p[2] & cla_p[1] & cla_g[0])
                 | (cla_p[3] & cla_p[2] & cla_p[1] & cla_p[0] & cla_c[0]);
        cla_sum = cla_p ^ cla_c[3:0];
    end

    // New sum nibble enters at the MSB end; after N shifts nibble 0 sits at the bottom
    assign acc_shift = WIDTH'({cla_sum, acc_q} >> 4);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        count_d = count_q;
`ifdef NIBBLE_SERIAL_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    x_d     = x;
                    y_d     = y;
                    carry_d = cIn;
                    count_d = '0;
`ifdef NIBBLE_SERIAL_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d     = x_q >> 4;
                y_d     = y_q >> 4;
                acc_d   = acc_shift;
                carry_d = cla_c[4];
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    s_d     = acc_shift;
                    cout_d  = cla_c[4];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            count_q <= count_d;
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    // inReady is gated by rst so it stays low for the whole reset pulse
    assign inReady  = (state_q == IDLE) && !rst;
    assign outValid = (state_q == DONE);
    assign s        = s_q;
    assign cOut     = cout_q;

endmodule
